// File: rtl/gpio_fifo_pkg.sv
// Shared GPIO bit layout for the serial-to-FIFO bridge: soft reset on bit 0,
// then three bits (sclk, sdata, write) per channel.
package gpio_fifo_pkg;

  localparam int SOFT_RST_BIT = 0;
  localparam int CH_BASE      = 1;
  localparam int SCLK_OFS     = 0;
  localparam int SDATA_OFS    = 1;
  localparam int WRITE_OFS    = 2;
  localparam int BITS_PER_CH  = 3;

  function automatic int gpio_idx(input int ch, input int ofs);
    return CH_BASE + ch * BITS_PER_CH + ofs;
  endfunction

endpackage

// File: rtl/gpio_serial_channel.sv
// One serial channel: edge detection on synchronised pins, MSB-first shifter,
// frame-length check, FIFO write pulse and saturating drop accounting.
module gpio_serial_channel
  import gpio_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              sdata,
  input  logic              write,
  input  logic              soft_rst,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_wr_en,
  output logic              frame_err,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int BW = $clog2(DATA_W + 2);
  localparam logic [BW-1:0] WORD_BITS = BW'(DATA_W);
  localparam logic [BW-1:0] OVER_BITS = BW'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              sclk_hist;
  logic              write_hist;
  logic              sclk_rise;
  logic              write_rise;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_cnt;

  assign sclk_rise  = sclk & ~sclk_hist;
  assign write_rise = write & ~write_hist;

  // A write edge wins over a coincident sclk edge and is judged on the pre-shift count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_hist  <= 1'b0;
      write_hist <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      fifo_dout  <= '0;
      fifo_wr_en <= 1'b0;
      frame_err  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      sclk_hist  <= sclk;
      write_hist <= write;
      fifo_wr_en <= 1'b0;
      if (soft_rst) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        frame_err <= 1'b0;
        drop_cnt  <= '0;
      end else if (write_rise) begin
        bit_cnt <= '0;
        if (sclk_rise) frame_err <= 1'b1;
        if (bit_cnt == WORD_BITS) begin
          if (!fifo_full) begin
            fifo_dout  <= shift_reg;
            fifo_wr_en <= 1'b1;
          end else if (drop_cnt != CNT_MAX) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end else if (sclk_rise) begin
        shift_reg <= {shift_reg[DATA_W-2:0], sdata};
        if (bit_cnt != OVER_BITS) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_to_fifo_multi.sv
// Multi-channel PS-GPIO bit-bang bridge: synchronises every GPIO input,
// derives the PL soft reset and fans the pins out to per-channel shifters.
module gpio_to_fifo_multi
  import gpio_fifo_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3*NUM_CH:0]        gpio_i,
  output logic                     rst_pl,
  input  logic [NUM_CH-1:0]        fifo_full,
  output logic [NUM_CH*DATA_W-1:0] fifo_dout,
  output logic [NUM_CH-1:0]        fifo_wr_en,
  output logic [NUM_CH-1:0]        frame_err,
  output logic [NUM_CH*CNT_W-1:0]  drop_cnt
);

  localparam int GW = CH_BASE + BITS_PER_CH * NUM_CH;

  logic [SYNC_STAGES-1:0][GW-1:0] sync_q;
  logic [GW-1:0]                  synced;

  // Synchroniser chain: stage 0 samples the pins, the last stage feeds the logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rst_pl = ~synced[SOFT_RST_BIT];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gpio_serial_channel #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .sclk       (synced[gpio_idx(c, SCLK_OFS)]),
      .sdata      (synced[gpio_idx(c, SDATA_OFS)]),
      .write      (synced[gpio_idx(c, WRITE_OFS)]),
      .soft_rst   (synced[SOFT_RST_BIT]),
      .fifo_full  (fifo_full[c]),
      .fifo_dout  (fifo_dout[c*DATA_W +: DATA_W]),
      .fifo_wr_en (fifo_wr_en[c]),
      .frame_err  (frame_err[c]),
      .drop_cnt   (drop_cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_gpio_to_fifo_multi.sv
// Randomised bench for gpio_to_fifo_multi: bit-bangs GPIO pins and checks pulses,
// words, frame errors and drop counts against a word-level reference model.
module tb_gpio_to_fifo_multi;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int SS  = 2;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3*NCH:0]    gpio_i = '0;
  logic              rst_pl;
  logic [NCH-1:0]    fifo_full = '0;
  logic [NCH*DW-1:0] fifo_dout;
  logic [NCH-1:0]    fifo_wr_en;
  logic [NCH-1:0]    frame_err;
  logic [NCH*CW-1:0] drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  gpio_to_fifo_multi #(.NUM_CH(NCH), .DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .gpio_i(gpio_i), .rst_pl(rst_pl), .fifo_full(fifo_full),
    .fifo_dout(fifo_dout), .fifo_wr_en(fifo_wr_en), .frame_err(frame_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed FIFO pushes, sampled shortly after each active edge.
  logic [DW-1:0] got_w [NCH][512];
  int            got_t [NCH][512];
  int            got_n [NCH];

  always @(posedge clk) begin
    #2;
    for (int c = 0; c < NCH; c++) begin
      if (fifo_wr_en[c] && got_n[c] < 512) begin
        got_w[c][got_n[c]] = fifo_dout[c*DW +: DW];
        got_t[c][got_n[c]] = cyc;
        got_n[c]++;
      end
    end
  end

  // Reference model: the last DW bits clocked in, how many bits since the last write,
  // sticky error, saturating drop count and the list of words expected in each FIFO.
  logic [63:0]   m_bits [NCH];
  int            m_cnt  [NCH];
  logic          m_err  [NCH];
  int            m_drop [NCH];
  logic          m_soft = 1'b0;
  logic [DW-1:0] exp_w  [NCH][512];
  int            exp_n  [NCH];
  int            wr_cyc [NCH];

  task automatic model_clear_state();
    for (int c = 0; c < NCH; c++) begin
      m_bits[c] = '0; m_cnt[c] = 0; m_err[c] = 1'b0; m_drop[c] = 0;
    end
  endtask

  task automatic clear_logs();
    for (int c = 0; c < NCH; c++) begin
      got_n[c] = 0; exp_n[c] = 0;
    end
  endtask

  task automatic model_bit(input int ch, input logic b);
    if (!m_soft) begin
      m_bits[ch] = {m_bits[ch][62:0], b};
      if (m_cnt[ch] <= DW) m_cnt[ch]++;
    end
  endtask

  task automatic model_write(input int ch, input logic collide);
    if (!m_soft) begin
      if (m_cnt[ch] == DW) begin
        if (fifo_full[ch]) begin
          if (m_drop[ch] < (1 << CW) - 1) m_drop[ch]++;
        end else begin
          exp_w[ch][exp_n[ch]] = m_bits[ch][DW-1:0];
          exp_n[ch]++;
        end
      end else begin
        m_err[ch] = 1'b1;
      end
      if (collide) m_err[ch] = 1'b1;
      m_cnt[ch] = 0;
    end
  endtask

  task automatic send_bit(input int ch, input logic b);
    gpio_i[2+3*ch] = b;
    gpio_i[1+3*ch] = 1'b1;
    @(negedge clk);
    gpio_i[1+3*ch] = 1'b0;
    @(negedge clk);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    model_bit(ch, b);
  endtask

  task automatic send_word(input int ch, input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(ch, w[i]);
  endtask

  task automatic do_write(input int ch, input int hold);
    gpio_i[3+3*ch] = 1'b1;
    wr_cyc[ch] = cyc;
    repeat (hold) @(negedge clk);
    gpio_i[3+3*ch] = 1'b0;
    repeat (2) @(negedge clk);
    model_write(ch, 1'b0);
  endtask

  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (rst_pl !== 1'b1) begin n_fail++; $display("FAIL reset_rst_pl: got %b want 1", rst_pl); end
    n_cmp++; if (fifo_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", fifo_dout); end
    n_cmp++; if (fifo_wr_en !== '0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_cmp++; if (frame_err !== '0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rst_pl !== 1'b1 || fifo_wr_en !== '0) begin
      n_fail++; $display("FAIL reset_release: rst_pl %b wr_en %b want 1/00", rst_pl, fifo_wr_en);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    send_word(0, 64'hDEADBEEF, 32);
    do_write(0, 2);
    settle();
    n_cmp++; if (got_n[0] !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", got_n[0]); end
    if (got_n[0] >= 1) begin
      n_cmp++; if (got_w[0][0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_word: got %h want deadbeef", got_w[0][0]); end
      n_cmp++; if (got_t[0][0] !== wr_cyc[0] + SS + 1) begin
        n_fail++; $display("FAIL basic_latency: pulse cycle %0d want %0d", got_t[0][0], wr_cyc[0] + SS + 1);
      end
    end
    n_cmp++; if (frame_err[0] !== 1'b0) begin n_fail++; $display("FAIL basic_frame_err: got %b want 0", frame_err[0]); end
    n_cmp++; if (fifo_dout[DW-1:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_hold: got %h want deadbeef", fifo_dout[DW-1:0]); end
  endtask

  task automatic test_drop();
    clear_logs();
    fifo_full[1] = 1'b1;
    send_word(1, 64'h12345678, 32);
    do_write(1, 2);
    settle();
    n_cmp++; if (drop_cnt[CW +: CW] !== 8'd1) begin n_fail++; $display("FAIL drop_first: got %0d want 1", drop_cnt[CW +: CW]); end
    for (int i = 0; i < 299; i++) begin
      send_word(1, 64'($urandom), 32);
      do_write(1, 1);
    end
    settle();
    fifo_full[1] = 1'b0;
    n_cmp++; if (drop_cnt[CW +: CW] !== 8'hFF || m_drop[1] !== 255) begin
      n_fail++; $display("FAIL drop_saturate: got %h want ff (model %0d)", drop_cnt[CW +: CW], m_drop[1]);
    end
    n_cmp++; if (got_n[1] !== 0) begin n_fail++; $display("FAIL drop_no_pulse: got %0d pulses want 0", got_n[1]); end
    n_cmp++; if (frame_err[1] !== 1'b0) begin n_fail++; $display("FAIL drop_frame_err: got %b want 0", frame_err[1]); end
  endtask

  task automatic test_frame_err();
    clear_logs();
    send_word(0, 64'($urandom), 31);
    do_write(0, 2);
    settle();
    n_cmp++; if (got_n[0] !== 0) begin n_fail++; $display("FAIL short_no_pulse: got %0d want 0", got_n[0]); end
    n_cmp++; if (frame_err[0] !== 1'b1) begin n_fail++; $display("FAIL short_frame_err: got %b want 1", frame_err[0]); end
    send_word(0, 64'h1, 32);
    do_write(0, 2);
    settle();
    n_cmp++; if (got_n[0] !== 1) begin n_fail++; $display("FAIL after_short_pulses: got %0d want 1", got_n[0]); end
    else begin
      n_cmp++; if (got_w[0][0] !== 32'h1) begin n_fail++; $display("FAIL after_short_word: got %h want 1", got_w[0][0]); end
    end
    n_cmp++; if (frame_err[0] !== 1'b1) begin n_fail++; $display("FAIL frame_err_sticky: got %b want 1", frame_err[0]); end
  endtask

  task automatic test_simultaneous();
    clear_logs();
    send_word(0, 64'hAAAA5555, 32);
    send_word(1, 64'h0F0F0F0F, 32);
    gpio_i[3] = 1'b1;
    gpio_i[6] = 1'b1;
    repeat (2) @(negedge clk);
    gpio_i[3] = 1'b0;
    gpio_i[6] = 1'b0;
    settle();
    model_write(0, 1'b0);
    model_write(1, 1'b0);
    n_cmp++; if (got_n[0] !== 1 || got_n[1] !== 1) begin
      n_fail++; $display("FAIL simul_pulses: got %0d/%0d want 1/1", got_n[0], got_n[1]);
    end else begin
      n_cmp++; if (got_t[0][0] !== got_t[1][0]) begin n_fail++; $display("FAIL simul_same_cycle: got %0d vs %0d", got_t[0][0], got_t[1][0]); end
      n_cmp++; if (got_w[0][0] !== 32'hAAAA5555) begin n_fail++; $display("FAIL simul_word0: got %h want aaaa5555", got_w[0][0]); end
      n_cmp++; if (got_w[1][0] !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL simul_word1: got %h want 0f0f0f0f", got_w[1][0]); end
    end
  endtask

  task automatic test_write_held();
    clear_logs();
    send_word(0, 64'($urandom), 32);
    do_write(0, 20);
    settle();
    n_cmp++; if (got_n[0] !== 1) begin n_fail++; $display("FAIL held_pulses: got %0d want 1", got_n[0]); end
    else begin
      n_cmp++; if (got_w[0][0] !== exp_w[0][0]) begin n_fail++; $display("FAIL held_word: got %h want %h", got_w[0][0], exp_w[0][0]); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] w;
    clear_logs();
    w = $urandom;
    send_word(1, 64'(w), 32);
    gpio_i[5] = 1'b1;
    gpio_i[4] = 1'b1;
    gpio_i[6] = 1'b1;
    repeat (2) @(negedge clk);
    gpio_i[4] = 1'b0;
    gpio_i[6] = 1'b0;
    repeat (2) @(negedge clk);
    model_write(1, 1'b1);
    settle();
    n_cmp++; if (frame_err[1] !== 1'b1) begin n_fail++; $display("FAIL collide_frame_err: got %b want 1", frame_err[1]); end
    n_cmp++; if (got_n[1] !== 1) begin n_fail++; $display("FAIL collide_pulses: got %0d want 1", got_n[1]); end
    else begin
      n_cmp++; if (got_w[1][0] !== w) begin n_fail++; $display("FAIL collide_word: got %h want %h", got_w[1][0], w); end
    end
    w = $urandom;
    send_word(1, 64'(w), 32);
    do_write(1, 2);
    settle();
    n_cmp++; if (got_n[1] !== 2) begin n_fail++; $display("FAIL collide_no_shift: got %0d pulses want 2", got_n[1]); end
    else begin
      n_cmp++; if (got_w[1][1] !== w) begin n_fail++; $display("FAIL collide_next_word: got %h want %h", got_w[1][1], w); end
    end
  endtask

  task automatic test_soft_reset();
    logic [NCH*DW-1:0] held;
    clear_logs();
    send_word(0, 64'($urandom), 16);
    held = fifo_dout;
    gpio_i[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if (rst_pl !== 1'b1) begin n_fail++; $display("FAIL soft_rst_pl_early: got %b want 1", rst_pl); end
    @(negedge clk);
    n_cmp++; if (rst_pl !== 1'b0) begin n_fail++; $display("FAIL soft_rst_pl: got %b want 0", rst_pl); end
    m_soft = 1'b1;
    model_clear_state();
    @(negedge clk);
    n_cmp++; if (frame_err !== '0 || drop_cnt !== '0) begin
      n_fail++; $display("FAIL soft_clear: frame_err %b drop_cnt %h want 0/0", frame_err, drop_cnt);
    end
    n_cmp++; if (fifo_dout !== held) begin n_fail++; $display("FAIL soft_dout_hold: got %h want %h", fifo_dout, held); end
    send_word(0, 64'($urandom), 8);
    send_word(0, 64'($urandom), 32);
    do_write(0, 2);
    settle();
    n_cmp++; if (got_n[0] !== 0) begin n_fail++; $display("FAIL soft_ignore: got %0d pulses want 0", got_n[0]); end
    gpio_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    m_soft = 1'b0;
    n_cmp++; if (rst_pl !== 1'b1) begin n_fail++; $display("FAIL soft_release: got %b want 1", rst_pl); end
    send_word(0, 64'hCAFEF00D, 32);
    do_write(0, 2);
    settle();
    n_cmp++; if (got_n[0] !== 1) begin n_fail++; $display("FAIL soft_after_pulses: got %0d want 1", got_n[0]); end
    else begin
      n_cmp++; if (got_w[0][0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL soft_after_word: got %h want cafef00d", got_w[0][0]); end
    end
  endtask

  task automatic test_random();
    int ch;
    int n;
    clear_logs();
    for (int i = 0; i < 12; i++) begin
      ch = $urandom_range(0, NCH - 1);
      case ($urandom_range(0, 5))
        0:       n = 30;
        1:       n = 33;
        default: n = 32;
      endcase
      fifo_full[ch] = ($urandom_range(0, 3) == 0);
      send_word(ch, {32'($urandom), 32'($urandom)}, n);
      do_write(ch, $urandom_range(1, 4));
      settle();
      fifo_full[ch] = 1'b0;
    end
    for (int c = 0; c < NCH; c++) begin
      n_cmp++; if (got_n[c] !== exp_n[c]) begin n_fail++; $display("FAIL rand_pulses ch%0d: got %0d want %0d", c, got_n[c], exp_n[c]); end
      for (int k = 0; k < exp_n[c] && k < got_n[c]; k++) begin
        n_cmp++; if (got_w[c][k] !== exp_w[c][k]) begin n_fail++; $display("FAIL rand_word ch%0d #%0d: got %h want %h", c, k, got_w[c][k], exp_w[c][k]); end
      end
      n_cmp++; if (frame_err[c] !== m_err[c]) begin n_fail++; $display("FAIL rand_frame_err ch%0d: got %b want %b", c, frame_err[c], m_err[c]); end
      n_cmp++; if (drop_cnt[c*CW +: CW] !== 8'(m_drop[c])) begin
        n_fail++; $display("FAIL rand_drop ch%0d: got %0d want %0d", c, drop_cnt[c*CW +: CW], m_drop[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    clear_logs();
    send_word(1, 64'($urandom), 5);
    do_write(1, 2);
    fifo_full[0] = 1'b1;
    send_word(0, 64'($urandom), 32);
    do_write(0, 2);
    fifo_full[0] = 1'b0;
    send_word(0, 64'($urandom), 10);
    settle();
    n_cmp++; if (frame_err[1] !== 1'b1 || drop_cnt[CW-1:0] !== 8'(m_drop[0])) begin
      n_fail++; $display("FAIL async_pre: frame_err %b drop0 %0d want 1/%0d", frame_err[1], drop_cnt[CW-1:0], m_drop[0]);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (fifo_dout !== '0 || fifo_wr_en !== '0) begin
      n_fail++; $display("FAIL async_data: dout %h wr_en %b want 0/0", fifo_dout, fifo_wr_en);
    end
    n_cmp++; if (frame_err !== '0 || drop_cnt !== '0) begin
      n_fail++; $display("FAIL async_state: frame_err %b drop_cnt %h want 0/0", frame_err, drop_cnt);
    end
    model_clear_state();
    clear_logs();
    @(negedge clk);
    rst = 1'b1;
    gpio_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rst_pl !== 1'b0) begin n_fail++; $display("FAIL async_soft_on: got %b want 0", rst_pl); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (rst_pl !== 1'b1) begin n_fail++; $display("FAIL async_rst_pl: got %b want 1", rst_pl); end
    @(negedge clk);
    gpio_i[0] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    w = $urandom;
    send_word(0, 64'(w), 32);
    do_write(0, 2);
    settle();
    n_cmp++; if (got_n[0] !== 1) begin n_fail++; $display("FAIL async_after_pulses: got %0d want 1", got_n[0]); end
    else begin
      n_cmp++; if (got_w[0][0] !== w) begin n_fail++; $display("FAIL async_after_word: got %h want %h", got_w[0][0], w); end
    end
  endtask

  initial begin
    model_clear_state();
    clear_logs();
    test_reset();
    test_basic();
    test_drop();
    test_frame_err();
    test_simultaneous();
    test_write_held();
    test_collision();
    test_soft_reset();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
